// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and the phase blocks around it.
//   phase_e         : phase encoding, matches the 2-bit state output
//   Res*            : choose_result encodings
//   phase_onehot()  : one-hot phase enable for a given phase
package game_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRoll   = 2'd1,
    StChoose = 2'd2,
    StDone   = 2'd3
  } phase_e;

  localparam logic [1:0] ResContinue = 2'b00;
  localparam logic [1:0] ResWin      = 2'b01;
  localparam logic [1:0] ResLose     = 2'b10;
  localparam logic [1:0] ResLoseAlt  = 2'b11;

  localparam int unsigned TurnsW = 4;

  function automatic logic [3:0] phase_onehot(input phase_e phase);
    phase_onehot = 4'b0001 << phase;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold counter for the DONE display time.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : forces the count to zero (wins over run)
//   run      : increment the count this cycle
//   expired  : count has reached HOLD_CYCLES-1 while running
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CntLast);

endmodule

// File: rtl/game_sequencer.sv
// Top-level phase sequencer for one game: IDLE -> ROLL -> CHOOSE -> (ROLL | DONE) -> IDLE.
//   clk, rst       : clock, asynchronous active-high reset
//   start_pulse    : start strobe, honoured in IDLE only
//   roll_pulse     : roll strobe, honoured in ROLL only
//   choose_pulse   : choose strobe, honoured in CHOOSE only, qualifies choose_result
//   choose_result  : 00 continue, 01 win, 1x lose
//   abort          : return to IDLE from any other phase, clears won/lost
//   state          : current phase (0 IDLE, 1 ROLL, 2 CHOOSE, 3 DONE)
//   enable         : one-hot phase enable decoded from state
//   turns          : completed turns in the current game
//   won, lost      : game outcome, held until the next start or reset
//   step           : one-cycle strobe the cycle after each state change
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned MAX_TURNS   = 9,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic       roll_pulse,
  input  logic       choose_pulse,
  input  logic [1:0] choose_result,
  input  logic       abort,
  output logic [1:0] state,
  output logic [3:0] enable,
  output logic [3:0] turns,
  output logic       won,
  output logic       lost,
  output logic       step
);

  localparam logic [TurnsW-1:0] MaxTurns = TurnsW'(MAX_TURNS);

  phase_e            state_q, state_d;
  logic [TurnsW-1:0] turns_q, turns_d;
  logic              won_q, won_d;
  logic              lost_q, lost_d;
  logic              step_q, step_d;
  logic [TurnsW-1:0] turn_inc;
  logic              hold_expired;
  logic              in_done;

  assign in_done = (state_q == StDone);

  // Counter sits at zero outside DONE, so it starts from zero on every entry.
  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_done),
    .run    (in_done),
    .expired(hold_expired)
  );

  // Saturating so turns can never pass the limit or wrap.
  assign turn_inc = (turns_q < MaxTurns) ? turns_q + TurnsW'(1) : turns_q;

  always_comb begin
    state_d = state_q;
    turns_d = turns_q;
    won_d   = won_q;
    lost_d  = lost_q;

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      won_d   = 1'b0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            state_d = StRoll;
            turns_d = '0;
            won_d   = 1'b0;
            lost_d  = 1'b0;
          end
        end
        StRoll: begin
          if (roll_pulse) begin
            state_d = StChoose;
          end
        end
        StChoose: begin
          if (choose_pulse) begin
            turns_d = turn_inc;
            if (choose_result == ResWin) begin
              state_d = StDone;
              won_d   = 1'b1;
            end else if ((choose_result == ResLose) || (choose_result == ResLoseAlt)) begin
              state_d = StDone;
              lost_d  = 1'b1;
            end else if (turn_inc == MaxTurns) begin
              state_d = StDone;
              lost_d  = 1'b1;
            end else begin
              state_d = StRoll;
            end
          end
        end
        StDone: begin
          if (hold_expired) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    step_d = (state_d != state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      turns_q <= '0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      turns_q <= turns_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
      step_q  <= step_d;
    end
  end

  assign state  = state_q;
  assign enable = phase_onehot(state_q);
  assign turns  = turns_q;
  assign won    = won_q;
  assign lost   = lost_q;
  assign step   = step_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with MAX_TURNS=3, HOLD_CYCLES=4.
module tb_game_sequencer;

  logic       clk;
  logic       rst;
  logic       start_pulse;
  logic       roll_pulse;
  logic       choose_pulse;
  logic [1:0] choose_result;
  logic       abort;
  logic [1:0] state;
  logic [3:0] enable;
  logic [3:0] turns;
  logic       won;
  logic       lost;
  logic       step;

  int unsigned n_checks;
  int unsigned n_errors;

  game_sequencer #(
    .MAX_TURNS  (3),
    .HOLD_CYCLES(4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start_pulse  (start_pulse),
    .roll_pulse   (roll_pulse),
    .choose_pulse (choose_pulse),
    .choose_result(choose_result),
    .abort        (abort),
    .state        (state),
    .enable       (enable),
    .turns        (turns),
    .won          (won),
    .lost         (lost),
    .step         (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_pulse   = 1'b0;
    roll_pulse    = 1'b0;
    choose_pulse  = 1'b0;
    choose_result = 2'b00;
    abort         = 1'b0;
  endtask

  task automatic do_start();
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic do_roll();
    roll_pulse = 1'b1;
    tick();
    roll_pulse = 1'b0;
  endtask

  task automatic do_choose(input logic [1:0] res);
    choose_pulse  = 1'b1;
    choose_result = res;
    tick();
    choose_pulse  = 1'b0;
    choose_result = 2'b00;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 8'(state), 8'd0);
    check({tag, "_enable"}, 8'(enable), 8'h01);
    check({tag, "_turns"}, 8'(turns), 8'd0);
    check({tag, "_won"}, 8'(won), 8'd0);
    check({tag, "_lost"}, 8'(lost), 8'd0);
    check({tag, "_step"}, 8'(step), 8'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_reset_values("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("post_reset");

    // Start a game.
    do_start();
    check("start_state", 8'(state), 8'd1);
    check("start_step", 8'(step), 8'd1);
    check("start_turns", 8'(turns), 8'd0);
    check("start_enable", 8'(enable), 8'h02);
    tick();
    check("start_step_drop", 8'(step), 8'd0);

    // Three continue rounds hit the turn limit.
    for (int i = 1; i <= 3; i++) begin
      do_roll();
      check($sformatf("limit_r%0d_choose", i), 8'(state), 8'd2);
      do_choose(2'b00);
      check($sformatf("limit_r%0d_turns", i), 8'(turns), 8'(i));
      check($sformatf("limit_r%0d_state", i), 8'(state), (i < 3) ? 8'd1 : 8'd3);
    end
    check("limit_lost", 8'(lost), 8'd1);
    check("limit_won", 8'(won), 8'd0);
    check("limit_enable", 8'(enable), 8'h08);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("hold_c%0d", k), 8'(state), 8'd3);
    end
    tick();
    check("hold_exit_state", 8'(state), 8'd0);
    check("hold_exit_step", 8'(step), 8'd1);
    check("hold_exit_turns", 8'(turns), 8'd3);
    check("hold_exit_lost", 8'(lost), 8'd1);

    // Foreign pulses in IDLE are ignored.
    do_roll();
    check("idle_roll_state", 8'(state), 8'd0);
    check("idle_roll_step", 8'(step), 8'd0);
    do_choose(2'b01);
    check("idle_choose_state", 8'(state), 8'd0);
    check("idle_choose_won", 8'(won), 8'd0);
    check("idle_choose_turns", 8'(turns), 8'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_state", 8'(state), 8'd0);
    check("idle_abort_step", 8'(step), 8'd0);
    check("idle_abort_lost", 8'(lost), 8'd1);

    // Start clears the previous outcome; start in ROLL is ignored.
    do_start();
    check("restart_turns", 8'(turns), 8'd0);
    check("restart_lost", 8'(lost), 8'd0);
    do_start();
    check("roll_start_state", 8'(state), 8'd1);
    check("roll_start_step", 8'(step), 8'd0);

    // Win on round 1.
    do_roll();
    do_choose(2'b01);
    check("win1_state", 8'(state), 8'd3);
    check("win1_won", 8'(won), 8'd1);
    check("win1_lost", 8'(lost), 8'd0);
    check("win1_turns", 8'(turns), 8'd1);
    for (int k = 0; k < 4; k++) tick();
    check("win1_idle", 8'(state), 8'd0);
    check("win1_persist", 8'(won), 8'd1);
    do_start();
    check("win1_restart_turns", 8'(turns), 8'd0);
    check("win1_restart_won", 8'(won), 8'd0);

    // Lose result 11.
    do_roll();
    do_choose(2'b11);
    check("lose11_state", 8'(state), 8'd3);
    check("lose11_lost", 8'(lost), 8'd1);
    check("lose11_turns", 8'(turns), 8'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("done_abort_state", 8'(state), 8'd0);
    check("done_abort_lost", 8'(lost), 8'd0);
    check("done_abort_step", 8'(step), 8'd1);

    // Win on the final allowed turn sets won only.
    do_start();
    for (int i = 0; i < 2; i++) begin
      do_roll();
      do_choose(2'b00);
    end
    do_roll();
    do_choose(2'b01);
    check("lastwin_turns", 8'(turns), 8'd3);
    check("lastwin_won", 8'(won), 8'd1);
    check("lastwin_lost", 8'(lost), 8'd0);
    for (int k = 0; k < 4; k++) tick();

    // Abort beats a simultaneous choose.
    do_start();
    do_roll();
    do_choose(2'b00);
    do_roll();
    abort = 1'b1;
    do_choose(2'b01);
    abort = 1'b0;
    check("abort_choose_state", 8'(state), 8'd0);
    check("abort_choose_won", 8'(won), 8'd0);
    check("abort_choose_turns", 8'(turns), 8'd1);
    check("abort_choose_step", 8'(step), 8'd1);

    // Asynchronous reset mid-CHOOSE, between edges.
    do_start();
    do_roll();
    check("pre_rst_state", 8'(state), 8'd2);
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    tick();
    rst = 1'b0;
    roll_pulse   = 1'b1;
    choose_pulse = 1'b1;
    tick();
    roll_pulse   = 1'b0;
    choose_pulse = 1'b0;
    check("post_rst_ignore", 8'(state), 8'd0);
    do_start();
    check("post_rst_start", 8'(state), 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter MAX_TURNS, default 9: turn limit per game; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 50_000_000: DONE-state display time in clk cycles (1 s at 50 MHz); legal minimum 2.
REQ-003 Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start_pulse  input  1  one-cycle strobe from the start phase.
- roll_pulse  input  1  one-cycle strobe from the roll phase.
- choose_pulse  input  1  one-cycle strobe from the choose phase.
- choose_result  input  2  qualified by choose_pulse; 00 continue, 01 win, 10 lose, 11 lose.
- abort  input  1  level or strobe; requests return to IDLE.
- state  output  2  current phase: 0 IDLE, 1 ROLL, 2 CHOOSE, 3 DONE.
- enable  output  4  one-hot phase enable; enable[state]=1.
- turns  output  4  completed turns in the current game.
- won  output  1  game ended by a win result.
- lost  output  1  game ended by a lose result or the turn limit.
- step  output  1  one-cycle strobe, asserted the cycle after any state change.

Function
REQ-004 state, turns, won, lost and step shall all be registered; enable shall decode combinationally from the state register.
REQ-005 A phase pulse shall be honoured only in its own phase: start_pulse in IDLE, roll_pulse in ROLL, choose_pulse in CHOOSE. Pulses in any other state shall be ignored with no side effects.
REQ-006 IDLE + start_pulse -> ROLL on the next edge; turns<=0, won<=0, lost<=0 on the same edge.
REQ-007 ROLL + roll_pulse -> CHOOSE on the next edge.
REQ-008 CHOOSE + choose_pulse -> turns<=turns+1 on the same edge, then exactly one of:
- result 01: -> DONE, won<=1.
- result 10/11: -> DONE, lost<=1.
- result 00 and turns+1==MAX_TURNS: -> DONE, lost<=1.
- otherwise: -> ROLL.
REQ-009 A win on the final allowed turn shall set won, not lost; won and lost shall never be 1 at the same time.
REQ-010 On entry to DONE, the hold counter shall clear and then increment every cycle. When the counter reaches HOLD_CYCLES-1, state -> IDLE on the next edge. DONE therefore lasts exactly HOLD_CYCLES cycles.
REQ-011 won, lost and turns shall persist through DONE and IDLE and clear only per REQ-006 or reset.
REQ-012 abort=1 in ROLL, CHOOSE or DONE shall force IDLE on the next edge and clear won and lost; turns shall be unchanged. abort in IDLE shall have no effect.
REQ-013 abort shall take priority over a simultaneous phase pulse or hold-counter expiry.
REQ-014 turns shall never exceed MAX_TURNS; there shall be no wrap-around.
REQ-015 step shall be 1 for exactly one cycle following each transition, including abort-driven transitions, and 0 otherwise.
REQ-016 The hold counter shall be at least ceil(log2(HOLD_CYCLES)) bits wide and shall not run outside DONE.

Reset
REQ-017 While rst=1: state=IDLE, enable=4'b0001, turns=0, won=0, lost=0, step=0, hold counter=0. Reset shall be effective immediately, without waiting for a clk edge.
REQ-018 Reset asserted mid-game, in any state, shall produce the REQ-017 values; the first edge after deassertion shall honour only start_pulse.

Structure
REQ-019 A shared package game_pkg shall hold the phase enum (IDLE, ROLL, CHOOSE, DONE) and the choose_result encoding constants; game_sequencer and the choose phase shall both import it.
REQ-020 The hold counter shall be a sub-module hold_timer (inputs clk, rst, clear, run; output expired), parameterised by HOLD_CYCLES.

Verification (bench overrides MAX_TURNS=3, HOLD_CYCLES=4)
REQ-021 Reset, then start_pulse -> state 0->1, step=1 for one cycle, turns=0, enable=0010.
REQ-022 Three rounds of roll_pulse then choose_pulse with result 00 -> turns 1,2,3; after the third choose, state=3, lost=1, won=0; state=0 exactly 4 cycles later, turns still 3.
REQ-023 Round 1 with result 01 -> state=3, won=1, turns=1; a later start_pulse -> turns=0, won=0.
REQ-024 roll_pulse and choose_pulse in IDLE, and start_pulse in ROLL -> state unchanged, step=0.
REQ-025 abort in the same cycle as choose_pulse (result 01) in CHOOSE -> state=0, won=0, turns unchanged.
REQ-026 rst asserted mid-CHOOSE between clk edges -> outputs reach REQ-017 values before the next edge.
